// File: rtl/aes_pkg.sv
// Shared AES-256 key schedule types, Rcon table and GF(2^8) S-box arithmetic.
package aes_pkg;

    typedef logic [127:0] aes_rk_t;
    typedef logic [31:0]  aes_word_t;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } ks_state_t;

    localparam int AES256_NUM_ROUND_KEYS = 15;

    // Entry 0 is unused padding so the table can be indexed directly by round/2.
    localparam logic [7:0] AES_RCON [0:7] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine map.
    function automatic logic [7:0] aes_sbox_calc(input logic [7:0] x);
        logic [7:0]  inv;
        logic [7:0]  pw;
        logic [15:0] dbl;
        logic [7:0]  s;
        inv = 8'h01;
        pw  = x;
        for (int i = 1; i < 8; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        dbl = {inv, inv};
        s   = inv ^ 8'h63;
        for (int k = 1; k < 5; k++) begin
            s = s ^ dbl[15-k -: 8];
        end
        return s;
    endfunction

endpackage

// File: rtl/aes256_key_schedule_seq_if.sv
// Key-in / round-key-out stream bundle for the sequential AES-256 key schedule.
interface aes256_key_schedule_seq_if;
    import aes_pkg::*;

    logic          key_valid;
    logic          key_ready;
    logic [255:0]  key_data;
    logic          rk_valid;
    logic          rk_ready;
    aes_rk_t       rk_data;
    logic [3:0]    rk_idx;
    logic          rk_last;
    logic          busy;

    modport master (
        output key_valid, key_data, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
    );

    modport slave (
        input  key_valid, key_data, rk_ready,
        output key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
    );

endinterface

// File: rtl/aes256_key_expansion_iter.sv
// One combinational AES-256 expansion step: next 128-bit half-key from the previous two.
module aes256_key_expansion_iter
    import aes_pkg::*;
(
    input  aes_rk_t    old_halfkey,
    input  aes_rk_t    halfkey,
    input  logic [3:0] round,
    output aes_rk_t    new_halfkey
);

    aes_word_t last_w;
    aes_word_t sub_in;
    aes_word_t sub_out;
    aes_word_t t;
    aes_word_t n0, n1, n2, n3;

    assign last_w = halfkey[31:0];
    // Odd rounds skip RotWord and Rcon; even rounds rotate left one byte.
    assign sub_in = round[0] ? last_w : {last_w[23:0], last_w[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .val     (sub_in[8*g +: 8]),
            .sub_val (sub_out[8*g +: 8])
        );
    end

    assign t  = round[0] ? sub_out : (sub_out ^ {AES_RCON[round[3:1]], 24'h000000});
    assign n0 = old_halfkey[127:96] ^ t;
    assign n1 = old_halfkey[95:64]  ^ n0;
    assign n2 = old_halfkey[63:32]  ^ n1;
    assign n3 = old_halfkey[31:0]   ^ n2;

    assign new_halfkey = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, computed arithmetically.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] val,
    output logic [7:0] sub_val
);

    assign sub_val = aes_sbox_calc(val);

endmodule

// File: rtl/aes256_key_schedule_seq.sv
// Sequential AES-256 key schedule streaming rk0..rk14, one per accepted beat.
// Optional AES256_KS_ZEROIZE_EN clears key material after rk14 and masks rk_data when idle.
module aes256_key_schedule_seq
    import aes_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    aes256_key_schedule_seq_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = 4'(AES256_NUM_ROUND_KEYS - 1);

    ks_state_t  state, state_nxt;
    aes_rk_t    half_a, half_b, half_b_nxt;
    logic [3:0] idx;
    logic [3:0] round;
    logic       key_hs, rk_hs;
    logic       key_ready, rk_valid;

    assign round = idx + 4'd2;

    aes256_key_expansion_iter u_iter (
        .old_halfkey (half_a),
        .halfkey     (half_b),
        .round       (round),
        .new_halfkey (half_b_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        key_hs    = 1'b0;
        rk_hs     = 1'b0;
        case (state)
            ST_IDLE: begin
                key_ready = 1'b1;
                key_hs    = bus.key_valid;
                if (key_hs) state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
                rk_valid = 1'b1;
                rk_hs    = bus.rk_ready;
                if (rk_hs && (idx == LAST_IDX)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A always holds the round key on display; B holds the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_a <= '0;
            half_b <= '0;
            idx    <= '0;
        end else if (key_hs) begin
            half_a <= bus.key_data[255:128];
            half_b <= bus.key_data[127:0];
            idx    <= '0;
        end else if (rk_hs) begin
            if (idx < LAST_IDX) begin
                half_a <= half_b;
                if (idx < LAST_IDX - 4'd1) half_b <= half_b_nxt;
                idx <= idx + 4'd1;
            end
`ifdef AES256_KS_ZEROIZE_EN
            else begin
                half_a <= '0;
                half_b <= '0;
            end
`endif
        end
    end

    assign bus.key_ready = key_ready;
    assign bus.rk_valid  = rk_valid;
    assign bus.busy      = rk_valid;
    assign bus.rk_idx    = idx;
    assign bus.rk_last   = rk_valid && (idx == LAST_IDX);
`ifdef AES256_KS_ZEROIZE_EN
    assign bus.rk_data   = rk_valid ? half_a : '0;
`else
    assign bus.rk_data   = half_a;
`endif

endmodule
